log2_histogram: RTL and testbench

- Statistics stage directly downstream of the log2 block. Consumes one (log2 result, power-of-2 flag) pair per strobed sample.
- Accumulates a per-bin histogram of log2 results, plus a zero-input count and an exact-power-of-2 count.
- On request, dumps all counts through a valid/ready stream, then self-clears.
- Used for dynamic-range profiling of data paths feeding the log2 stage.

---
 rtl/log2_histogram.sv | 133 +++++++++++++
 tb/tb_log2_histogram.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/log2_histogram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// log2_histogram : per-bin histogram of log2 results plus zero/pow2 counts,
//                  dumped on request over valid/ready, then self-cleared.
// Revision       : 1.0
// ---------------------------------------------------------------------------
module log2_histogram #(
  parameter int M     = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic [M-1:0]     in_log2,
  input  logic             in_pow2,
  input  logic             dump_req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [M:0]       out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_last,
  output logic             busy,
  output logic             lost
);

  localparam int               NB       = 1 << M;
  localparam logic [M:0]       ZERO_IDX = (M+1)'(NB);
  localparam logic [M:0]       LAST_IDX = (M+1)'(NB + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DUMP  = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [M:0]       idx_q, idx_d;
  logic [CNT_W-1:0] bin_q [NB];
  logic [CNT_W-1:0] bin_d [NB];
  logic [CNT_W-1:0] zero_q, zero_d;
  logic [CNT_W-1:0] pow2_q, pow2_d;
  logic             lost_q, lost_d;
  logic             is_zero;
  logic [CNT_W-1:0] sel_count;

  assign is_zero = (in_log2 == '0) && !in_pow2;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bin_d   = bin_q;
    zero_d  = zero_q;
    pow2_d  = pow2_q;
    lost_d  = lost_q;
    case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          // Saturating counters: hold at max and flag the loss.
          if (is_zero) begin
            if (zero_q == CNT_MAX) lost_d = 1'b1;
            else                   zero_d = zero_q + 1'b1;
          end else begin
            if (bin_q[in_log2] == CNT_MAX) lost_d = 1'b1;
            else                           bin_d[in_log2] = bin_q[in_log2] + 1'b1;
          end
          if (in_pow2) begin
            if (pow2_q == CNT_MAX) lost_d = 1'b1;
            else                   pow2_d = pow2_q + 1'b1;
          end
        end
        if (dump_req) begin
          state_d = S_DUMP;
          idx_d   = '0;
        end
      end
      S_DUMP: begin
        if (in_vld) lost_d = 1'b1;
        if (out_ready) begin
          if (idx_q == LAST_IDX) state_d = S_CLEAR;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      S_CLEAR: begin
        for (int i = 0; i < NB; i++) bin_d[i] = '0;
        zero_d  = '0;
        pow2_d  = '0;
        // A sample dropped in the clear cycle is still reported.
        lost_d  = in_vld;
        idx_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      zero_q  <= '0;
      pow2_q  <= '0;
      lost_q  <= 1'b0;
      for (int i = 0; i < NB; i++) bin_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      zero_q  <= zero_d;
      pow2_q  <= pow2_d;
      lost_q  <= lost_d;
      bin_q   <= bin_d;
    end
  end

  always_comb begin
    sel_count = '0;
    if (idx_q < ZERO_IDX)       sel_count = bin_q[idx_q[M-1:0]];
    else if (idx_q == ZERO_IDX) sel_count = zero_q;
    else                        sel_count = pow2_q;
  end

  assign out_valid = (state_q == S_DUMP);
  assign out_idx   = idx_q;
  assign out_count = out_valid ? sel_count : '0;
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign busy      = (state_q == S_DUMP) || (state_q == S_CLEAR);
  assign lost      = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_log2_histogram.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_log2_histogram : directed stimulus with a queue scoreboard on the dump stream.
// Revision          : 1.0
// ---------------------------------------------------------------------------
module tb_log2_histogram;

  localparam int M     = 3;
  localparam int CNT_W = 4;
  localparam int NW    = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_vld = 1'b0;
  logic [M-1:0]     in_log2 = '0;
  logic             in_pow2 = 1'b0;
  logic             dump_req = 1'b0;
  logic             out_ready = 1'b1;
  logic             out_valid;
  logic [M:0]       out_idx;
  logic [CNT_W-1:0] out_count;
  logic             out_last;
  logic             busy;
  logic             lost;

  log2_histogram #(.M(M), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_log2(in_log2), .in_pow2(in_pow2),
    .dump_req(dump_req), .out_ready(out_ready), .out_valid(out_valid),
    .out_idx(out_idx), .out_count(out_count), .out_last(out_last),
    .busy(busy), .lost(lost)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int cnt; int last; } word_t;
  word_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int l, input int p);
    in_vld  = 1'b1;
    in_log2 = M'(l);
    in_pow2 = p[0];
    tick();
    in_vld  = 1'b0;
  endtask

  task automatic push_exp(input int e[NW]);
    for (int i = 0; i < NW; i++) exp_q.push_back('{i, e[i], (i == NW-1) ? 1 : 0});
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("idle_timeout", busy, 0);
  endtask

  task automatic run_dump(input int e[NW]);
    push_exp(e);
    out_ready = 1'b1;
    dump_req  = 1'b1;
    tick();
    dump_req  = 1'b0;
    chk("first_valid", out_valid, 1);
    chk("first_idx", out_idx, 0);
    wait_idle();
    chk("q_drained", exp_q.size(), 0);
  endtask

  // Monitor: pops on handshake, checks stability against the head while stalled.
  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word_idx", out_idx, -1);
      end else if (out_ready) begin
        chk("word_idx", out_idx, exp_q[0].idx);
        chk("word_count", out_count, exp_q[0].cnt);
        chk("word_last", out_last, exp_q[0].last);
        void'(exp_q.pop_front());
      end else begin
        chk("stall_idx", out_idx, exp_q[0].idx);
        chk("stall_count", out_count, exp_q[0].cnt);
      end
    end
  end

  initial begin
    // Reset mid-stream
    #12 rst = 1'b1;
    tick();
    strobe(3, 1);
    strobe(0, 0);
    #3 rst = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lost", lost, 0);
    #7 rst = 1'b1;
    tick();
    run_dump('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    // Classification with exact dump timing
    strobe(0, 0); strobe(0, 0); strobe(0, 1); strobe(3, 1);
    strobe(3, 0); strobe(3, 0); strobe(7, 0);
    chk("class_lost", lost, 0);
    push_exp('{1, 0, 0, 3, 0, 0, 0, 1, 2, 2});
    out_ready = 1'b1;
    dump_req  = 1'b1;
    tick();
    dump_req  = 1'b0;
    for (int i = 0; i < NW; i++) tick();
    chk("clear_valid", out_valid, 0);
    chk("clear_busy", busy, 1);
    tick();
    chk("after_clear_busy", busy, 0);
    chk("class_q_drained", exp_q.size(), 0);

    // Backpressure at idx 4
    strobe(4, 1); strobe(6, 0); strobe(6, 0);
    push_exp('{0, 0, 0, 0, 1, 0, 2, 0, 0, 1});
    out_ready = 1'b1;
    dump_req  = 1'b1;
    tick();
    dump_req  = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("stall_hold_idx", out_idx, 4);
    chk("stall_hold_valid", out_valid, 1);
    out_ready = 1'b1;
    wait_idle();
    chk("bp_q_drained", exp_q.size(), 0);

    // Sample with dump_req, drop during dump, dump_req while busy
    push_exp('{0, 0, 0, 0, 0, 1, 0, 0, 0, 1});
    out_ready = 1'b1;
    in_vld = 1'b1; in_log2 = 3'd5; in_pow2 = 1'b1; dump_req = 1'b1;
    tick();
    in_vld = 1'b0; dump_req = 1'b0;
    chk("sim_lost_before", lost, 0);
    tick();
    strobe(2, 0);
    chk("drop_lost", lost, 1);
    dump_req = 1'b1;
    tick();
    dump_req = 1'b0;
    chk("drop_lost_held", lost, 1);
    chk("drop_busy", busy, 1);
    wait_idle();
    chk("drop_lost_cleared", lost, 0);
    tick(); tick();
    chk("no_requeue_valid", out_valid, 0);
    chk("no_requeue_busy", busy, 0);
    chk("drop_q_drained", exp_q.size(), 0);

    // Saturation
    for (int i = 0; i < 15; i++) strobe(1, 0);
    chk("sat_lost_15", lost, 0);
    strobe(1, 0);
    chk("sat_lost_16", lost, 1);
    strobe(1, 0);
    chk("sat_lost_17", lost, 1);
    run_dump('{0, 15, 0, 0, 0, 0, 0, 0, 0, 0});
    chk("sat_lost_cleared", lost, 0);

    // Reset mid-dump at idx 3
    strobe(6, 1);
    exp_q.push_back('{0, 0, 0});
    exp_q.push_back('{1, 0, 0});
    exp_q.push_back('{2, 0, 0});
    out_ready = 1'b1;
    dump_req  = 1'b1;
    tick();
    dump_req  = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("pre_abort_idx", out_idx, 3);
    rst = 1'b0;
    #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_q_drained", exp_q.size(), 0);
    #4 rst = 1'b1;
    tick();
    run_dump('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0});

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
